// File: rtl/kp_pkg.sv
// Shared definitions for the front-panel keypad scanner: geometry, key codes,
// debounce state encoding and the (row, col) -> key code map.
package kp_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [1:0] {
    RELEASED,
    PRESSING,
    PRESSED,
    RELEASING
  } kp_state_e;

  // Rows 0..2 hold digits 1..9 left to right; the bottom row is '*', 0, '#'.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row != 2'd3) begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end else begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        2'd2:    code = KEY_HASH;
        default: code = KEY_NONE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-rate debounce of the scan candidate: a key must be seen alone for
// DEBOUNCE_SCANS frames to be accepted, and absent as long to be released.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RELEASED  | no key held; waiting for a lone candidate
// PRESSING  | counting consecutive frames of the latched candidate
// PRESSED   | held_code accepted and reported
// RELEASING | counting consecutive frames without the held key
module key_debounce
  import kp_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_end,
  input  logic [3:0] cand_code,
  output logic [3:0] held_code,
  output logic       strobe
);

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_SCANS);

  kp_state_e  state;
  logic [3:0] cand_q;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RELEASED;
      cand_q    <= KEY_NONE;
      cnt       <= '0;
      held_code <= KEY_NONE;
      strobe    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (frame_end) begin
        case (state)
          RELEASED: begin
            if (cand_code != KEY_NONE) begin
              cand_q <= cand_code;
              if (DB_MAX == 4'd1) begin
                state     <= PRESSED;
                held_code <= cand_code;
                strobe    <= 1'b1;
                cnt       <= '0;
              end else begin
                state <= PRESSING;
                cnt   <= 4'd1;
              end
            end
          end
          PRESSING: begin
            // A different key drops back to RELEASED rather than restarting.
            if (cand_code == cand_q) begin
              if (cnt + 4'd1 == DB_MAX) begin
                state     <= PRESSED;
                held_code <= cand_q;
                strobe    <= 1'b1;
                cnt       <= '0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              state <= RELEASED;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (cand_code != held_code) begin
              if (DB_MAX == 4'd1) begin
                state     <= RELEASED;
                held_code <= KEY_NONE;
                cnt       <= '0;
              end else begin
                state <= RELEASING;
                cnt   <= 4'd1;
              end
            end
          end
          RELEASING: begin
            if (cand_code != held_code) begin
              if (cnt + 4'd1 == DB_MAX) begin
                state     <= RELEASED;
                held_code <= KEY_NONE;
                cnt       <= '0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: begin
            state     <= RELEASED;
            held_code <= KEY_NONE;
            cnt       <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 membrane keypad scanner: row drive, column synchronizer, per-frame
// single-key candidate and registered one-hot key outputs.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [KP_COLS-1:0] cols_n,
  output logic [KP_ROWS-1:0] rows_n,
  output logic [9:0]         keypad,
  output logic               key_star,
  output logic               key_hash,
  output logic               key_strobe
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [KP_COLS-1:0] sync1, sync2;
  logic [DW-1:0]      dwell;
  logic [1:0]         row;
  logic [1:0]         frame_hits;
  logic [3:0]         frame_code;
  logic               sample;
  logic               frame_end;
  logic [1:0]         row_hits;
  logic [3:0]         row_code;
  logic [3:0]         hit_code;
  logic [2:0]         total_hits;
  logic [3:0]         cand_code;
  logic [3:0]         held_code;
  logic               db_strobe;

  assign sample    = (dwell == DWELL_LAST);
  assign frame_end = sample && (row == 2'd3);

  always_comb begin
    row_hits = '0;
    row_code = KEY_NONE;
    for (int c = 0; c < KP_COLS; c++) begin
      if (!sync2[c]) begin
        row_hits = row_hits + 2'd1;
        row_code = key_code(row, 2'(c));
      end
    end
  end

  // With exactly one hit in the frame, whichever side saw it owns the code.
  assign total_hits = {1'b0, frame_hits} + {1'b0, row_hits};
  assign hit_code   = (row_hits != 2'd0) ? row_code : frame_code;
  assign cand_code  = (total_hits == 3'd1) ? hit_code : KEY_NONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1      <= '1;
      sync2      <= '1;
      dwell      <= '0;
      row        <= '0;
      rows_n     <= 4'b1110;
      frame_hits <= '0;
      frame_code <= KEY_NONE;
    end else begin
      sync1 <= cols_n;
      sync2 <= sync1;
      if (sample) begin
        dwell  <= '0;
        row    <= row + 2'd1;
        rows_n <= ~(KP_ROWS'(1) << (row + 2'd1));
        if (frame_end) begin
          frame_hits <= '0;
          frame_code <= KEY_NONE;
        end else begin
          // Two hits already means "multi-key" for the rest of the frame.
          frame_hits <= (total_hits > 3'd1) ? 2'd2 : total_hits[1:0];
          frame_code <= hit_code;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  key_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .resetn    (resetn),
    .frame_end (frame_end),
    .cand_code (cand_code),
    .held_code (held_code),
    .strobe    (db_strobe)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keypad     <= '0;
      key_star   <= 1'b0;
      key_hash   <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      keypad     <= (held_code < 4'd10) ? (10'd1 << held_code) : '0;
      key_star   <= (held_code == KEY_STAR);
      key_hash   <= (held_code == KEY_HASH);
      key_strobe <= db_strobe;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level key model drives the columns and
// predicts every output each cycle; directed literals pin key timings.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] cols_n;
  logic [3:0] rows_n;
  logic [9:0] keypad;
  logic       key_star, key_hash, key_strobe;

  logic [11:0] held_keys = '0;
  int edges      = 0;
  int total      = 0;
  int bad        = 0;
  int strobe_cnt = 0;

  int m_held = 15, m_track = 15, m_streak = 0, m_strobe_next = 0;
  int exp_held = 15, exp_strobe = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cols_n     (cols_n),
    .rows_n     (rows_n),
    .keypad     (keypad),
    .key_star   (key_star),
    .key_hash   (key_hash),
    .key_strobe (key_strobe)
  );

  function automatic int code_at(int r, int c);
    if (r < 3) return r * 3 + c + 1;
    if (c == 0) return 10;
    if (c == 1) return 0;
    return 11;
  endfunction

  // Physical keypad: a held key shorts its row to its column.
  always_comb begin
    cols_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!rows_n[r] && held_keys[code_at(r, c)]) cols_n[c] = 1'b0;
  end

  always @(posedge clk or negedge resetn)
    if (!resetn) edges <= 0;
    else         edges <= edges + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, req, edges);
    end
  endtask

  // One frame of the key-level behaviour: lone key seen DB frames running is
  // accepted; held key missing DB frames running is dropped.
  task automatic model_step();
    int n, cand;
    n    = $countones(held_keys);
    cand = 15;
    if (n == 1)
      for (int k = 0; k < 12; k++) if (held_keys[k]) cand = k;
    if (m_held == 15) begin
      if (cand == 15)              m_streak = 0;
      else if (m_streak == 0)      begin m_track = cand; m_streak = 1; end
      else if (cand == m_track)    m_streak++;
      else                         m_streak = 0;
      if (m_streak >= DB) begin
        m_held = m_track; m_streak = 0; m_strobe_next = 1;
      end
    end else begin
      if (cand == m_held) m_streak = 0;
      else                m_streak++;
      if (m_streak >= DB) begin m_held = 15; m_streak = 0; end
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      m_held = 15; m_track = 15; m_streak = 0; m_strobe_next = 0;
      exp_held = 15; exp_strobe = 0;
      check("rst_rows",   int'(rows_n), 4'b1110);
      check("rst_keypad", int'(keypad), 0);
      check("rst_star",   int'(key_star), 0);
      check("rst_hash",   int'(key_hash), 0);
      check("rst_strobe", int'(key_strobe), 0);
    end else begin
      int ek;
      if (edges % FRAME == FRAME - 1) model_step();
      if (edges % FRAME == 1 && edges > 1) begin
        exp_held = m_held; exp_strobe = m_strobe_next; m_strobe_next = 0;
      end else begin
        exp_strobe = 0;
      end
      ek = (exp_held < 10) ? (1 << exp_held) : 0;
      check("rows",   int'(rows_n), 15 ^ (1 << ((edges / SCAN_DIV) % 4)));
      check("keypad", int'(keypad), ek);
      check("star",   int'(key_star), (exp_held == 10) ? 1 : 0);
      check("hash",   int'(key_hash), (exp_held == 11) ? 1 : 0);
      check("strobe", int'(key_strobe), exp_strobe);
      if (key_strobe) strobe_cnt++;
    end
  end

  task automatic goto(input int n);
    int guard = 0;
    while (edges != n) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        $display("FAIL goto: edge %0d never reached (at %0d)", n, edges);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
      end
    end
    #1;
  endtask

  task automatic release_all();
    held_keys = '0;
    goto(edges + 4 * FRAME);
  endtask

  logic [3:0] row_exp [5];
  int base;

  initial begin
    row_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      goto(4 * i);
      check("rows_lit", int'(rows_n), int'(row_exp[i]));
    end
    strobe_cnt = 0;
    goto(20 * FRAME);
    check("idle_strobes", strobe_cnt, 0);
    check("idle_keypad", int'(keypad), 0);

    // key 5 from a frame start: accepted 3 frames + 1 clk later
    base = edges; strobe_cnt = 0; held_keys = 12'd1 << 5;
    goto(base + 48);  check("k5_early", int'(keypad), 0);
    goto(base + 49);  check("k5_accept", int'(keypad), 10'b0000100000);
    goto(base + 13 * FRAME); check("k5_strobes", strobe_cnt, 1);
    release_all();

    // bounce key 7: 2 frames on, 1 off
    strobe_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      held_keys = 12'd1 << 7; goto(edges + 2 * FRAME);
      held_keys = '0;         goto(edges + FRAME);
    end
    check("bounce_strobes", strobe_cnt, 0);
    check("bounce_keypad", int'(keypad), 0);

    // keys 1 and 2 together, then 1 alone
    strobe_cnt = 0; held_keys = (12'd1 << 1) | (12'd1 << 2);
    goto(edges + 10 * FRAME);
    check("multi_strobes", strobe_cnt, 0);
    base = edges; held_keys = 12'd1 << 1;
    goto(base + 49); check("k1_accept", int'(keypad), 10'b0000000010);
    goto(base + 4 * FRAME); check("k1_strobes", strobe_cnt, 1);
    release_all();

    // rollover 5 -> 0
    base = edges; strobe_cnt = 0; held_keys = 12'd1 << 5;
    goto(base + 3 * FRAME); held_keys = 12'd1 << 0;
    goto(base + 6 * FRAME + 1); check("roll0_released", int'(keypad), 0);
    goto(base + 9 * FRAME);     check("roll0_early", int'(keypad), 0);
    goto(base + 9 * FRAME + 1); check("roll0_accept", int'(keypad), 10'b0000000001);
    goto(base + 10 * FRAME);    check("roll0_strobes", strobe_cnt, 2);
    release_all();

    // rollover 5 -> '*'
    base = edges; strobe_cnt = 0; held_keys = 12'd1 << 5;
    goto(base + 3 * FRAME); held_keys = 12'd1 << 10;
    goto(base + 9 * FRAME + 1);
    check("rollstar_star", int'(key_star), 1);
    check("rollstar_keypad", int'(keypad), 0);
    goto(base + 10 * FRAME); check("rollstar_strobes", strobe_cnt, 2);
    release_all();

    // reset mid-PRESSING with key 9 held
    base = edges; held_keys = 12'd1 << 9;
    goto(base + 2 * FRAME + 5);
    resetn = 1'b0;
    #1;
    check("midrst_rows", int'(rows_n), 4'b1110);
    check("midrst_keypad", int'(keypad), 0);
    check("midrst_strobe", int'(key_strobe), 0);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1; strobe_cnt = 0;
    goto(48); check("k9_early", int'(keypad), 0);
    goto(49); check("k9_accept", int'(keypad), 10'b1000000000);
    goto(4 * FRAME); check("k9_strobes", strobe_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the physical 4x3 membrane keypad of the microwave front panel and produces the decimal key vector that the digit encoder consumes, plus levels for the '*' and '#' keys.
- Scans rows one at a time, samples the synchronized columns, rejects multi-key ghosting, and debounces whole scan frames.
- Outputs a clean one-hot level per stable key and a single-cycle press strobe.

Parameters:
- SCAN_DIV, 4: clocks each row stays driven (dwell). Must be >= 4 for synchronizer and settle time.
- DEBOUNCE_SCANS, 3: consecutive identical scan frames needed to accept a press or a release. Range 1..15.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cols_n  in  3  keypad column sense, active-low, asynchronous; bit0 = left column
- rows_n  out  4  row drive, active-low, exactly one bit low at any time; bit0 = top row
- keypad  out  10  one-hot stable digit: bit k = key k held. All zero when no digit key is held.
- key_star  out  1  level: '*' stably held
- key_hash  out  1  level: '#' stably held
- key_strobe  out  1  one-cycle pulse when any key (digit, '*' or '#') becomes accepted

Behaviour:
- Reset, asynchronous: rows_n=4'b1110, keypad=0, key_star=0, key_hash=0, key_strobe=0, all counters 0, FSM in RELEASED, synchronizer flops 3'b111.
- Key map (row, col):
  - r0 = 1,2,3
  - r1 = 4,5,6
  - r2 = 7,8,9
  - r3 = *,0,#
- cols_n passes through a 2-flop synchronizer before any use.
- Scan:
  - Dwell counter runs 0..SCAN_DIV-1.
  - Synchronized columns are sampled when the counter equals SCAN_DIV-1, then the row advances r0→r1→r2→r3→r0 on the next cycle.
  - One frame = 4*SCAN_DIV cycles and ends at the r3 sample.
- Frame candidate:
  - Exactly one key seen in the frame → its 4-bit code: 0-9 digits, 10 = '*', 11 = '#'.
  - Zero keys, or two or more keys → NONE (15). Multi-key is never reported.
- FSM, evaluated only at frame end:
  - RELEASED: candidate ≠ NONE → PRESSING, latch cand_code, cnt=1.
    - If DEBOUNCE_SCANS=1, go directly to PRESSED instead.
  - PRESSING: candidate = cand_code → cnt++; when cnt reaches DEBOUNCE_SCANS → PRESSED, held_code=cand_code, assert key_strobe.
    - Any other candidate → RELEASED, cnt=0. A different key does not restart the count directly.
  - PRESSED: candidate ≠ held_code (NONE, multi-key or another key) → RELEASING, cnt=1.
  - RELEASING: candidate ≠ held_code → cnt++; at DEBOUNCE_SCANS → RELEASED, held_code cleared.
    - candidate = held_code → back to PRESSED, no strobe.
- Key-to-key rollover: the held key must be fully released before a new key can be accepted. No strobe is issued for the new key until it is debounced from RELEASED.
- Outputs are registered and decoded from held_code in PRESSED/RELEASING.
  - They change on the clock edge after the frame-end sample.
  - key_strobe is high for exactly that one cycle.
- Latency: a press stable from the start of a frame is accepted DEBOUNCE_SCANS frames later, plus 1 clk.
- key_strobe never asserts twice without an intervening accepted release.
- Reset asserted mid-scan or mid-debounce aborts immediately to the reset state. No strobe follows reset release until a full debounce completes.

Decomposition:
- Shared package (kp_pkg):
  - KP_ROWS=4, KP_COLS=3
  - key codes KEY_STAR=10, KEY_HASH=11, KEY_NONE=15
  - FSM state encoding RELEASED/PRESSING/PRESSED/RELEASING
- Sub-module key_debounce: frame-end-driven FSM plus count, taking candidate code and frame_end, returning held_code and strobe.
- Scan counter, synchronizer and candidate logic stay in keypad_scanner.

Test Plan:
- Reset with SCAN_DIV=4, DEBOUNCE_SCANS=3, no keys:
  - rows_n=1110, then cycles 1101/1011/0111/1110 every 4 clk.
  - keypad=0, key_strobe never pulses over 20 frames.
- Hold key 5 (cols_n bit1 low while rows_n[1]=0) from frame start:
  - keypad=10'b0000100000 exactly 3 frames + 1 clk later (49 clk).
  - Exactly one key_strobe; none over a further 10 frames.
- Bounce key 7 as present 2 frames / absent 1 frame, repeated 8 times:
  - keypad stays 0 and key_strobe never pulses.
- Hold keys 1 and 2 together for 10 frames:
  - keypad stays 0 and no strobe.
  - Then release 2, keeping 1 → keypad bit1 after 3 more frames, one strobe.
- Hold 5 until accepted, then switch to 0 with no gap:
  - keypad goes 0 after 3 frames.
  - keypad=10'b0000000001 after 3 further frames, with one new strobe.
  - Repeat with '*' → key_star=1, keypad=0.
- Assert resetn low mid-PRESSING for 2 clk while key 9 is held:
  - All outputs 0 immediately, rows_n=1110.
  - Accept 9 again only after 3 full frames from reset release.
